// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI initiator: 10-bit command frames out on MOSI, 8-bit read replies in from MISO
module spi_master #(
  parameter int FRAME_W  = 10,
  parameter int DATA_W   = 8,
  parameter int TURN_CYC = 2,
  parameter int GAP_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_cmd,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              seq_err,
  output logic              busy,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  typedef enum logic [2:0] {IDLE, START, SHIFT, TURN, CAPTURE, STOP} state_t;

  state_t              state, state_nx;
  logic [3:0]          cnt, cnt_nx;
  logic [FRAME_W-1:0]  frame;
  logic [DATA_W-1:0]   cap;
  logic                rd_pending;
  logic                mosi_nx;
  logic                ss_n_nx;
  logic                accept;
  logic                is_rd_data;

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = req_ready && req_valid;
  assign is_rd_data = (frame[FRAME_W-1 -: 2] == 2'b11);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE:    if (req_valid) state_nx = START;
      START: begin
        state_nx = SHIFT;
        cnt_nx   = 4'(FRAME_W - 1);
      end
      SHIFT: begin
        if (cnt == 4'd0) begin
          if (is_rd_data) begin
            state_nx = TURN;
            cnt_nx   = 4'(TURN_CYC - 1);
          end else begin
            state_nx = STOP;
            cnt_nx   = 4'(GAP_CYC - 1);
          end
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      TURN: begin
        if (cnt == 4'd0) begin
          state_nx = CAPTURE;
          cnt_nx   = 4'(DATA_W - 1);
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      CAPTURE: begin
        if (cnt == 4'd0) begin
          state_nx = STOP;
          cnt_nx   = 4'(GAP_CYC - 1);
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      STOP: begin
        if (cnt == 4'd0) state_nx = IDLE;
        else             cnt_nx = cnt - 4'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // SS_n/MOSI are registered, so they are derived from the state being entered.
  always_comb begin
    mosi_nx = 1'b0;
    ss_n_nx = 1'b1;
    case (state_nx)
      START: begin
        ss_n_nx = 1'b0;
        mosi_nx = req_cmd[1];
      end
      SHIFT: begin
        ss_n_nx = 1'b0;
        mosi_nx = frame[cnt_nx];
      end
      TURN, CAPTURE: ss_n_nx = 1'b0;
      default: ss_n_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      frame      <= '0;
      cap        <= '0;
      rd_pending <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      seq_err    <= 1'b0;
      SS_n       <= 1'b1;
      MOSI       <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      SS_n      <= ss_n_nx;
      MOSI      <= mosi_nx;
      rsp_valid <= 1'b0;
      seq_err   <= accept && (req_cmd == 2'b11) && !rd_pending;
      if (accept) frame <= {req_cmd, req_data};
      if (state == SHIFT && cnt == 4'd0 && frame[FRAME_W-1 -: 2] == 2'b10)
        rd_pending <= 1'b1;
      if (state == CAPTURE) begin
        cap <= {cap[DATA_W-2:0], MISO};
        if (cnt == 4'd0) begin
          rsp_data   <= {cap[DATA_W-2:0], MISO};
          rsp_valid  <= 1'b1;
          rd_pending <= 1'b0;
        end
      end
    end
  end

endmodule
